led_pulse_checker: RTL and testbench
====================================

Name: led_pulse_checker

Overview:
- Receive-side counterpart of the board's LED pulse generator.
- Monitors a 4-bit pulse pattern that should alternate 0xA/0x5 at a fixed half-period, for example from a loopback header or a second board.
- Filters glitches, measures the half-period, and reports lock, errors and an error count.
- Used as a bring-up and cabling sanity check on the 10 MHz clock domain.

Parameters:
- HALF_PERIOD, 4166667: expected cycles between pattern changes; matches the generator at 10 MHz, 1.2 Hz.
- TOL, 4096: accepted deviation in cycles, ± around HALF_PERIOD.
- LOCK_COUNT, 4: consecutive good changes needed to assert lock.
- STABLE_CYCLES, 16: cycles the synchronized input must hold before it is accepted.
- CW, $clog2(HALF_PERIOD+TOL+2): width of the distance counter (derived).

Ports:
- clk_10MHz  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- pat_in  in  4  asynchronous pattern input.
- locked  out  1  pattern tracked within tolerance.
- err  out  1  single-cycle pulse on loss of lock.
- err_count  out  16  saturating count of loss-of-lock events.
- pattern_now  out  4  current filtered pattern.
- period_meas  out  CW  distance in cycles measured at the last accepted change.

Behaviour:
- Reset: the interface is decided as reset resetn, synchronous, active-low; clock clk_10MHz. While resetn is low on a rising edge:
  - locked=0, err=0, err_count=0, pattern_now=0, period_meas=0
  - state=HUNT, distance counter=0, good counter=0, synchronizer and filter registers=0.
  - A reset applied mid-operation takes effect at the next edge, regardless of state.
- Synchronizer: 2-flop synchronizer on each bit of pat_in.
- Glitch filter:
  - The candidate equals the synchronizer output.
  - The stability counter increments while the candidate is unchanged and clears when it changes.
  - When the candidate has been unchanged for STABLE_CYCLES consecutive cycles and differs from pattern_now, pattern_now loads the candidate. That cycle is an "event".
  - Filter delay is constant, so measured distances are preserved. Glitches shorter than STABLE_CYCLES never produce an event.
- Distance counter D:
  - Loads 1 on every event.
  - Otherwise increments, saturating at its all-ones value.
  - At an event, D equals the cycles since the previous event.
- Valid value: 0xA or 0x5.
- Good event, in TRACK or LOCKED: new pattern_now == ~previous pattern_now, the new value is valid, and HALF_PERIOD-TOL <= D <= HALF_PERIOD+TOL (inclusive at both ends).
- Bad condition, evaluated only in TRACK or LOCKED:
  - an event that is not good, or
  - timeout: no event and D == HALF_PERIOD+TOL+1.
  - An event arriving in the timeout cycle counts as a single bad condition.
- period_meas loads D on every event in TRACK or LOCKED, good or bad.
- State machine:
  - HUNT: on an event to a valid value go to TRACK with good counter=0. Invalid values and timeouts are ignored.
  - TRACK, good event: good counter += 1. When it reaches LOCK_COUNT, go to LOCKED.
  - TRACK, bad condition: go to HUNT silently (no err).
  - LOCKED, good event: remain in LOCKED.
  - LOCKED, bad condition: err=1 for one cycle, err_count += 1 (saturating at 0xFFFF), go to HUNT. An event in that same cycle does not seed TRACK.
- locked is registered: 1 exactly while state==LOCKED, and it rises or falls on the edge that enters or leaves LOCKED.
- err is registered and is 0 in every other cycle.

Optional Feature:
- Macro: PULSE_CHK_ANY_COMPLEMENT_EN.
- Defined: every 4-bit value is valid, so any alternating complementary pair (e.g. 0x3/0xC) can lock. 0x0/0xF is also accepted.
- Undefined: only 0xA and 0x5 are valid. Any other value in TRACK or LOCKED is a bad event, and HUNT ignores it.

Test Plan:
Bench parameters: HALF_PERIOD=100, TOL=4, LOCK_COUNT=4, STABLE_CYCLES=3.
1. Release reset; pat_in alternates 0xA/0x5 every 100 cycles -> locked=1 on the 4th good event after the seed; period_meas=100; err never pulses; err_count=0.
2. Locked; one half-period of 96, then one of 104 -> both accepted. Next half-period of 95 -> err pulses for 1 cycle, err_count=1, locked=0; relocks after 4 more good events.
3. Locked; pat_in stuck at 0xA -> err at D=105 (105 cycles after the last event), err_count increments by 1, state HUNT; no further errors while stuck.
4. Locked; 2-cycle glitch to 0xF mid-period -> no event, pattern_now unchanged, locked stays 1.
5. Locked; pattern changes to 0x3 at D=100 -> err, err_count +1. With the macro undefined, repeated 0x3/0xC never locks; with PULSE_CHK_ANY_COMPLEMENT_EN defined it locks after 4 good events.
6. err_count preloaded to 0xFFFF by forcing repeated losses -> stays at 0xFFFF. Assert resetn low for 1 cycle while locked -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/led_pulse_checker.sv
// Receive-side checker for the alternating 0xA/0x5 LED pulse pattern: synchronize, glitch-filter, measure, lock.
// Define PULSE_CHK_ANY_COMPLEMENT_EN to accept any complementary pair, not only 0xA/0x5.
`timescale 1ns/1ps
module led_pulse_checker #(
  parameter int HALF_PERIOD   = 4166667,
  parameter int TOL           = 4096,
  parameter int LOCK_COUNT    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CW            = $clog2(HALF_PERIOD + TOL + 2)
) (
  input  logic          clk_10MHz,
  input  logic          resetn,
  input  logic [3:0]    pat_in,
  output logic          locked,
  output logic          err,
  output logic [15:0]   err_count,
  output logic [3:0]    pattern_now,
  output logic [CW-1:0] period_meas,
  output logic [1:0]    state_o
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] D_MIN = CW'(HALF_PERIOD - TOL);
  localparam logic [CW-1:0] D_MAX = CW'(HALF_PERIOD + TOL);
  localparam logic [CW-1:0] D_TO  = CW'(HALF_PERIOD + TOL + 1);
  // The candidate has been held (stab_q + 2) cycles when it matches cand_q.
  localparam logic [SW-1:0] STAB_HIT = SW'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q, cand_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [3:0]    pattern_q, pattern_d;
  logic [CW-1:0] dist_q, dist_d;
  logic [GW-1:0] good_q, good_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [CW-1:0] period_q, period_d;

  logic ev, new_valid, good_ev, active, bad;

  always_comb begin
    stab_d = stab_q;
    if (sync2_q != cand_q) begin
      stab_d = '0;
    end else if (stab_q != '1) begin
      stab_d = stab_q + SW'(1);
    end
  end

  assign ev = (sync2_q == cand_q) && (stab_q >= STAB_HIT) && (sync2_q != pattern_q);

`ifdef PULSE_CHK_ANY_COMPLEMENT_EN
  assign new_valid = 1'b1;
`else
  assign new_valid = (sync2_q == 4'hA) || (sync2_q == 4'h5);
`endif

  assign good_ev = ev && new_valid && (sync2_q == ~pattern_q) &&
                   (dist_q >= D_MIN) && (dist_q <= D_MAX);
  assign active  = (state_q == ST_TRACK) || (state_q == ST_LOCKED);
  // An event landing on the timeout cycle is judged as an event only.
  assign bad     = active && (ev ? !good_ev : (dist_q == D_TO));

  always_comb begin
    pattern_d = ev ? sync2_q : pattern_q;
    dist_d    = dist_q;
    if (ev) begin
      dist_d = CW'(1);
    end else if (dist_q != '1) begin
      dist_d = dist_q + CW'(1);
    end
  end

  always_ff @(posedge clk_10MHz) begin
    if (!resetn) begin
      state_q     <= ST_HUNT;
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      stab_q      <= '0;
      pattern_q   <= '0;
      dist_q      <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= pat_in;
      sync2_q     <= sync1_q;
      cand_q      <= sync2_q;
      stab_q      <= stab_d;
      pattern_q   <= pattern_d;
      dist_q      <= dist_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      period_q    <= period_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ST_HUNT: begin
        if (ev && new_valid) begin
          state_d = ST_TRACK;
          good_d  = '0;
        end
      end
      ST_TRACK: begin
        if (bad) begin
          state_d = ST_HUNT;
        end else if (good_ev) begin
          good_d = good_q + GW'(1);
          if (good_q == GW'(LOCK_COUNT - 1)) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (bad) begin
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    locked_d    = (state_d == ST_LOCKED);
    err_d       = (state_q == ST_LOCKED) && bad;
    err_count_d = err_count_q;
    if (err_d && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
    period_d = (ev && active) ? dist_q : period_q;
  end

  assign locked      = locked_q;
  assign err         = err_q;
  assign err_count   = err_count_q;
  assign pattern_now = pattern_q;
  assign period_meas = period_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_led_pulse_checker.sv
// Directed bench for led_pulse_checker: segment table for lock/tolerance/glitch, hand sequences for timeout, saturation, reset.
`timescale 1ns/1ps
module tb_led_pulse_checker;

  localparam int HP = 100;
  localparam int TL = 4;
  localparam int LC = 4;
  localparam int SC = 3;
  localparam int CW = $clog2(HP + TL + 2);
  localparam logic [1:0] HUNT = 2'd0, TRK = 2'd1, LCK = 2'd2;

  logic          clk_10MHz = 1'b0;
  logic          resetn = 1'b0;
  logic [3:0]    pat_in = 4'h0;
  logic          locked, err;
  logic [15:0]   err_count;
  logic [3:0]    pattern_now;
  logic [CW-1:0] period_meas;
  logic [1:0]    state_o;

  led_pulse_checker #(
    .HALF_PERIOD(HP), .TOL(TL), .LOCK_COUNT(LC), .STABLE_CYCLES(SC)
  ) dut (
    .clk_10MHz(clk_10MHz), .resetn(resetn), .pat_in(pat_in),
    .locked(locked), .err(err), .err_count(err_count),
    .pattern_now(pattern_now), .period_meas(period_meas), .state_o(state_o)
  );

  always #50 clk_10MHz = ~clk_10MHz;

  typedef struct {
    logic [3:0] pat;
    int         hold;
    logic [1:0] st;
    logic       lk;
    logic [3:0] pn;
    int         per;
    int         errs;
    int         cnt;
  } vec_t;

  vec_t vecs[20];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int err_pulses = 0;
  int last_ev_cyc = 0;
  logic [3:0] last_pn = 4'h0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: outputs sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge clk_10MHz);
    cyc++;
    if (err) err_pulses++;
    if (pattern_now != last_pn) begin
      last_pn = pattern_now;
      last_ev_cyc = cyc;
    end
  endtask

  task automatic run_seg(input logic [3:0] p, input int hold);
    pat_in = p;
    err_pulses = 0;
    repeat (hold) tick();
  endtask

  task automatic relock(input string tag, input logic [3:0] p);
    for (int j = 0; j < 5; j++) begin
      run_seg((j % 2 == 0) ? p : ~p, HP);
    end
    chk({tag, "_locked"}, 32'(locked), 32'(1));
    chk({tag, "_state"}, 32'(state_o), 32'(LCK));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'(0));
    chk({tag, "_err"}, 32'(err), 32'(0));
    chk({tag, "_err_count"}, 32'(err_count), 32'(0));
    chk({tag, "_pattern_now"}, 32'(pattern_now), 32'(0));
    chk({tag, "_period_meas"}, 32'(period_meas), 32'(0));
    chk({tag, "_state"}, 32'(state_o), 32'(HUNT));
  endtask

  initial begin
    // Lock-up, tolerance edges, relock, glitch, then a non-complement change.
    vecs[0]  = '{4'hA, 100, TRK,  1'b0, 4'hA,   0, 0, 0};
    vecs[1]  = '{4'h5, 100, TRK,  1'b0, 4'h5, 100, 0, 0};
    vecs[2]  = '{4'hA, 100, TRK,  1'b0, 4'hA, 100, 0, 0};
    vecs[3]  = '{4'h5, 100, TRK,  1'b0, 4'h5, 100, 0, 0};
    vecs[4]  = '{4'hA, 100, LCK,  1'b1, 4'hA, 100, 0, 0};
    vecs[5]  = '{4'h5, 100, LCK,  1'b1, 4'h5, 100, 0, 0};
    vecs[6]  = '{4'hA,  96, LCK,  1'b1, 4'hA, 100, 0, 0};
    vecs[7]  = '{4'h5, 104, LCK,  1'b1, 4'h5,  96, 0, 0};
    vecs[8]  = '{4'hA,  95, LCK,  1'b1, 4'hA, 104, 0, 0};
    vecs[9]  = '{4'h5, 100, HUNT, 1'b0, 4'h5,  95, 1, 1};
    vecs[10] = '{4'hA, 100, TRK,  1'b0, 4'hA,  95, 0, 1};
    vecs[11] = '{4'h5, 100, TRK,  1'b0, 4'h5, 100, 0, 1};
    vecs[12] = '{4'hA, 100, TRK,  1'b0, 4'hA, 100, 0, 1};
    vecs[13] = '{4'h5, 100, TRK,  1'b0, 4'h5, 100, 0, 1};
    vecs[14] = '{4'hA, 100, LCK,  1'b1, 4'hA, 100, 0, 1};
    vecs[15] = '{4'h5,  50, LCK,  1'b1, 4'h5, 100, 0, 1};
    vecs[16] = '{4'hF,   2, LCK,  1'b1, 4'h5, 100, 0, 1};
    vecs[17] = '{4'h5,  48, LCK,  1'b1, 4'h5, 100, 0, 1};
    vecs[18] = '{4'hA, 100, LCK,  1'b1, 4'hA, 100, 0, 1};
    vecs[19] = '{4'h3, 100, HUNT, 1'b0, 4'h3, 100, 1, 2};

    // Reset with a live pattern on the pins: nothing may leak through.
    resetn = 1'b0;
    pat_in = 4'hA;
    repeat (4) tick();
    check_reset_outputs("reset");
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_seg(vecs[i].pat, vecs[i].hold);
      chk($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(vecs[i].lk));
      chk($sformatf("v%0d_pattern_now", i), 32'(pattern_now), 32'(vecs[i].pn));
      chk($sformatf("v%0d_period_meas", i), 32'(period_meas), 32'(vecs[i].per));
      chk($sformatf("v%0d_err_pulses", i), 32'(err_pulses), 32'(vecs[i].errs));
      chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].cnt));
    end
    exp_cnt = 2;

    // Alternating 0x3/0xC from HUNT.
    for (int k = 0; k < 6; k++) begin
      logic [1:0] est;
      logic       elk;
      run_seg((k % 2 == 0) ? 4'hC : 4'h3, HP);
`ifdef PULSE_CHK_ANY_COMPLEMENT_EN
      est = (k < 4) ? TRK : LCK;
      elk = (k >= 4);
`else
      est = HUNT;
      elk = 1'b0;
`endif
      chk($sformatf("c%0d_state", k), 32'(state_o), 32'(est));
      chk($sformatf("c%0d_locked", k), 32'(locked), 32'(elk));
      chk($sformatf("c%0d_pattern_now", k), 32'(pattern_now), 32'((k % 2 == 0) ? 4'hC : 4'h3));
      chk($sformatf("c%0d_err_count", k), 32'(err_count), 32'(exp_cnt));
    end
    run_seg(4'h3, 300);
`ifdef PULSE_CHK_ANY_COMPLEMENT_EN
    chk("c_stuck_err_pulses", 32'(err_pulses), 32'(1));
    exp_cnt++;
`else
    chk("c_stuck_err_pulses", 32'(err_pulses), 32'(0));
`endif
    chk("c_stuck_state", 32'(state_o), 32'(HUNT));

    // Stuck pattern while locked: err exactly HP+TOL+1 cycles after the last event.
    relock("t3_relock", 4'hA);
    begin
      int  err_cyc;
      bit  seen;
      seen = 1'b0;
      err_cyc = 0;
      for (int w = 0; w < 400 && !seen; w++) begin
        tick();
        if (err) begin
          seen = 1'b1;
          err_cyc = cyc;
        end
      end
      chk("t3_err_seen", 32'(seen), 32'(1));
      chk("t3_timeout_distance", 32'(err_cyc - last_ev_cyc), 32'(HP + TL + 1));
    end
    exp_cnt++;
    chk("t3_err_count", 32'(err_count), 32'(exp_cnt));
    tick();
    chk("t3_err_single", 32'(err), 32'(0));
    chk("t3_state", 32'(state_o), 32'(HUNT));
    chk("t3_locked", 32'(locked), 32'(0));
    run_seg(4'hA, 300);
    chk("t3_no_more_errs", 32'(err_pulses), 32'(0));
    chk("t3_err_count_hold", 32'(err_count), 32'(exp_cnt));

    // Saturation: preload the counter near its ceiling, then lose lock twice.
    relock("t6_relock1", 4'h5);
    force dut.err_count_q = 16'hFFFE;
    tick();
    tick();
    release dut.err_count_q;
    run_seg(4'h5, 250);
    chk("t6_loss1_pulses", 32'(err_pulses), 32'(1));
    chk("t6_count_ffff", 32'(err_count), 32'(16'hFFFF));
    relock("t6_relock2", 4'hA);
    run_seg(4'hA, 250);
    chk("t6_loss2_pulses", 32'(err_pulses), 32'(1));
    chk("t6_count_sat", 32'(err_count), 32'(16'hFFFF));

    // One-cycle reset while locked clears everything on the next edge.
    relock("t6_relock3", 4'h5);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_reset_outputs("t6_midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
